// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes, FSM states
// and the single-iteration datapath mode.
package mul_div_unit_pkg;

    localparam int MD_WIDTH = 32;

    typedef enum logic [2:0] {
        OP_MULTU = 3'b000,
        OP_MULT  = 3'b001,
        OP_DIVU  = 3'b010,
        OP_DIV   = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    typedef enum logic {
        MODE_MUL,
        MODE_DIV
    } step_mode_e;

    // Opcodes 000..011 launch an iterative operation; bit 0 selects the signed variant.
    function automatic logic is_muldiv(logic [2:0] op);
        return (op[2] == 1'b0);
    endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the register-file stage and the mul/div unit.
interface mul_div_unit_if
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] busA;
    logic [WIDTH-1:0] busB;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (
        output Start, Op, busA, busB,
        input  Busy, Done, HI, LO
    );

    modport slave (
        input  Start, Op, busA, busB,
        output Busy, Done, HI, LO
    );
endinterface

// File: rtl/mul_div_unit_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract for divide.
// The accumulator holds {partial/remainder, multiplier/dividend} in both modes.
module muldiv_step
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  step_mode_e           mode_i,
    input  logic [2*WIDTH-1:0]   acc_i,
    input  logic [WIDTH-1:0]     opnd_i,
    output logic [2*WIDTH-1:0]   acc_o
);

    logic [WIDTH:0] mul_sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, opnd_i} : '0);
        rem_sh  = {acc_i[2*WIDTH-1:WIDTH], acc_i[WIDTH-1]};
        diff    = rem_sh - {1'b0, opnd_i};

        // The remainder is always below the divisor, so diff[WIDTH] is a clean borrow flag.
        if (mode_i == MODE_MUL) begin
            acc_o = {mul_sum, acc_i[WIDTH-1:1]};
        end else if (!diff[WIDTH]) begin
            acc_o = {diff[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
        end else begin
            acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mul_div_unit.sv
// MIPS HI/LO multiply/divide unit: magnitude-based iterative core with a final
// sign-fix cycle, plus MTHI/MTLO writes while idle.
module mul_div_unit
    import mul_div_unit_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int ITER  = MD_WIDTH
) (
    input  logic          CLK,
    input  logic          Reset,
    mul_div_unit_if.slave bus
);

    localparam int CW = $clog2(ITER);
    localparam int AW = 2 * WIDTH;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [AW-1:0]    acc_q, acc_d, acc_step;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] araw_q, araw_d;
    step_mode_e       mode_q, mode_d;
    logic             neg_qt_q, neg_qt_d;
    logic             neg_rm_q, neg_rm_d;
    logic             div_zero_q, div_zero_d;

    logic             start_md;
    logic             signed_op;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [AW-1:0]    prod;
    logic [WIDTH-1:0] rem;

    assign start_md  = bus.Start && is_muldiv(bus.Op);
    assign signed_op = bus.Op[0];
    assign mag_a     = (signed_op && bus.busA[WIDTH-1]) ? -bus.busA : bus.busA;
    assign mag_b     = (signed_op && bus.busB[WIDTH-1]) ? -bus.busB : bus.busB;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode_i (mode_q),
        .acc_i  (acc_q),
        .opnd_i (opnd_q),
        .acc_o  (acc_step)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_md) state_d = S_RUN;
            S_RUN:   if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.Busy = (state_q != S_IDLE);
    end

    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    // NOTE: every variable gets its hold value first, so no path through this block can infer a latch.
    always_comb begin
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        acc_d      = acc_q;
        opnd_d     = opnd_q;
        araw_d     = araw_q;
        mode_d     = mode_q;
        neg_qt_d   = neg_qt_q;
        neg_rm_d   = neg_rm_q;
        div_zero_d = div_zero_q;
        prod       = neg_qt_q ? -acc_q : acc_q;
        rem        = acc_q[AW-1:WIDTH];

        case (state_q)
            S_IDLE: begin
                if (start_md) begin
                    mode_d     = bus.Op[1] ? MODE_DIV : MODE_MUL;
                    neg_qt_d   = signed_op & (bus.busA[WIDTH-1] ^ bus.busB[WIDTH-1]);
                    neg_rm_d   = signed_op & bus.busA[WIDTH-1];
                    div_zero_d = (bus.busB == '0);
                    araw_d     = bus.busA;
                    cnt_d      = '0;
                    if (bus.Op[1]) begin
                        opnd_d = mag_b;
                        acc_d  = {{WIDTH{1'b0}}, mag_a};
                    end else begin
                        opnd_d = mag_a;
                        acc_d  = {{WIDTH{1'b0}}, mag_b};
                    end
                end else if (bus.Start && bus.Op == OP_MTHI) begin
                    hi_d = bus.busA;
                end else if (bus.Start && bus.Op == OP_MTLO) begin
                    lo_d = bus.busA;
                end
            end
            S_RUN: begin
                acc_d = acc_step;
                cnt_d = cnt_q + CW'(1);
            end
            S_FIX: begin
                done_d = 1'b1;
                if (mode_q == MODE_MUL) begin
                    hi_d = prod[AW-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else if (div_zero_q) begin
                    hi_d = araw_q;
                    lo_d = '1;
                end else begin
                    hi_d = neg_rm_q ? -rem : rem;
                    lo_d = neg_qt_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            done_q <= done_d;
        end
    end

    // NOTE: working operands are reloaded on every launch and never observed in IDLE, so they carry no reset.
    always_ff @(posedge CLK) begin
        acc_q      <= acc_d;
        opnd_q     <= opnd_d;
        araw_q     <= araw_d;
        mode_q     <= mode_d;
        neg_qt_q   <= neg_qt_d;
        neg_rm_q   <= neg_rm_d;
        div_zero_q <= div_zero_d;
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit with a cycle-level reference model of the HI/LO unit.
module tb_mul_div_unit;
    import mul_div_unit_pkg::*;

    logic CLK;
    logic Reset;

    mul_div_unit_if #(.WIDTH(32)) bus ();

    mul_div_unit #(.WIDTH(32), .ITER(32)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural result of each operation, from plain 64-bit arithmetic.
    function automatic logic [63:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, rm;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (op)
            OP_MULTU: r = {32'b0, a} * {32'b0, b};
            OP_MULT:  r = sa * sb;
            OP_DIVU:  r = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
            OP_DIV: begin
                if (b == 0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else begin
                    q  = sa / sb;
                    rm = sa % sb;
                    r  = {rm[31:0], q[31:0]};
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    // Reference model: a busy countdown of 33 cycles, then the result lands with a Done pulse.
    int          m_rem  = 0;
    logic        m_done = 1'b0;
    logic [31:0] m_hi   = '0;
    logic [31:0] m_lo   = '0;
    logic [63:0] m_res  = '0;

    always @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            m_rem  <= 0;
            m_done <= 1'b0;
            m_hi   <= '0;
            m_lo   <= '0;
        end else begin
            m_done <= 1'b0;
            if (m_rem != 0) begin
                m_rem <= m_rem - 1;
                if (m_rem == 1) begin
                    m_hi   <= m_res[63:32];
                    m_lo   <= m_res[31:0];
                    m_done <= 1'b1;
                end
            end else if (bus.Start) begin
                if (bus.Op[2] == 1'b0) begin
                    m_res <= golden(bus.Op, bus.busA, bus.busB);
                    m_rem <= 33;
                end else if (bus.Op == OP_MTHI) begin
                    m_hi <= bus.busA;
                end else if (bus.Op == OP_MTLO) begin
                    m_lo <= bus.busA;
                end
            end
        end
    end

    always @(negedge CLK) begin
        check("model_busy", 32'(bus.Busy), 32'(m_rem != 0));
        check("model_done", 32'(bus.Done), 32'(m_done));
        check("model_hi",   bus.HI, m_hi);
        check("model_lo",   bus.LO, m_lo);
    end

    // Presents a request for exactly one rising edge; returns at the negedge of cycle 1.
    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge CLK);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.busA  = a;
        bus.busB  = b;
        @(negedge CLK);
        bus.Start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        forever begin
            lat++;
            if (bus.Busy) busy_n++;
            if (bus.Done || lat >= 100) break;
            @(negedge CLK);
        end
        check("done_seen", 32'(bus.Done), 32'd1);
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int lat, busy_n;
        do_op(op, a, b);
        wait_done(lat, busy_n);
        check({name, "_latency"}, 32'(lat), 32'd34);
        check({name, "_busy_cycles"}, 32'(busy_n), 32'd33);
        check({name, "_hi"}, bus.HI, exp_hi);
        check({name, "_lo"}, bus.LO, exp_lo);
        @(negedge CLK);
        check({name, "_done_one_cycle"}, 32'(bus.Done), 32'd0);
    endtask

    initial begin
        int lat, busy_n, done_cnt, idle_n, gap_done;
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        bus.busA  = '0;
        bus.busB  = '0;
        Reset     = 1'b0;
        #2 Reset  = 1'b1;
        repeat (3) @(negedge CLK);
        Reset = 1'b0;
        check("reset_busy", 32'(bus.Busy), 32'd0);
        check("reset_done", 32'(bus.Done), 32'd0);
        check("reset_hi", bus.HI, 32'd0);
        check("reset_lo", bus.LO, 32'd0);

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_m1",   OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_op("div_m7_2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("divu_100_7", OP_DIVU, 32'd100,       32'd7,         32'd2,         32'd14);
        run_op("divu_by0",  OP_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("mult_mixed", OP_MULT, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1);

        // MTHI while idle lands on the next edge without raising Busy.
        do_op(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
        check("mthi_hi", bus.HI, 32'hDEAD_BEEF);
        check("mthi_busy", 32'(bus.Busy), 32'd0);
        check("mthi_done", 32'(bus.Done), 32'd0);

        // Asynchronous reset in the middle of a multiply.
        do_op(OP_MULTU, 32'd3, 32'd5);
        repeat (8) @(negedge CLK);
        @(posedge CLK);
        #3 Reset = 1'b1;
        #1;
        check("abort_busy", 32'(bus.Busy), 32'd0);
        check("abort_hi", bus.HI, 32'd0);
        check("abort_lo", bus.LO, 32'd0);
        @(negedge CLK);
        Reset = 1'b0;
        done_cnt = 0;
        repeat (40) begin
            @(negedge CLK);
            if (bus.Done) done_cnt++;
        end
        check("abort_no_done", 32'(done_cnt), 32'd0);

        // MTLO issued during Busy must be dropped.
        do_op(OP_MULTU, 32'h0001_0000, 32'h0003_0003);
        repeat (5) @(negedge CLK);
        bus.Start = 1'b1;
        bus.Op    = OP_MTLO;
        bus.busA  = 32'h0000_0001;
        @(negedge CLK);
        bus.Start = 1'b0;
        wait_done(lat, busy_n);
        check("mtlo_ignored_hi", bus.HI, 32'h0000_0003);
        check("mtlo_ignored_lo", bus.LO, 32'h0003_0000);
        @(negedge CLK);

        // Start held high: the second op is accepted on the Done cycle only.
        bus.Start = 1'b1;
        bus.Op    = OP_MULT;
        bus.busA  = 32'd2;
        bus.busB  = 32'd3;
        idle_n    = 0;
        gap_done  = 0;
        for (int i = 1; i <= 67; i++) begin
            @(negedge CLK);
            if (!bus.Busy) idle_n++;
            if (!bus.Busy && bus.Done) gap_done++;
        end
        bus.Start = 1'b0;
        check("b2b_idle_cycles", 32'(idle_n), 32'd1);
        check("b2b_gap_is_done", 32'(gap_done), 32'd1);
        @(negedge CLK);
        wait_done(lat, busy_n);
        check("b2b_hi", bus.HI, 32'd0);
        check("b2b_lo", bus.LO, 32'd6);
        repeat (3) @(negedge CLK);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Iterative multiply/divide unit with the HI/LO register pair for the MIPS datapath.
- Sits directly downstream of the register file: consumes busA (rs) and busB (rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Its HI/LO outputs feed the write-back mux (mfhi/mflo) that drives the register file WriteData.
- Busy stalls the pipeline while an operation runs.

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- ITER, 32, iteration cycles per mul/div; must equal WIDTH.

Ports:
- CLK  in  1  system clock; all state updates on posedge.
- Reset  in  1  asynchronous, active-high reset.
- Start  in  1  operation request, sampled on posedge.
- Op  in  3  000 MULTU, 001 MULT, 010 DIVU, 011 DIV, 100 MTHI, 101 MTLO; 110/111 no-op.
- busA  in  WIDTH  rs value (multiplicand / dividend / MTHI-MTLO source).
- busB  in  WIDTH  rt value (multiplier / divisor).
- Busy  out  1  high while a mul/div is in progress.
- Done  out  1  one-cycle pulse when HI/LO receive a mul/div result.
- HI  out  WIDTH  HI register (product high half / remainder).
- LO  out  WIDTH  LO register (product low half / quotient).

Behaviour:
- Reset (asynchronous, active-high; clock and reset are CLK and Reset):
  - Any time Reset=1: state=IDLE, HI=0, LO=0, Busy=0, Done=0, iteration counter=0.
  - Reset mid-operation aborts it with no partial result written.
- States: IDLE, RUN, FIX.
- IDLE:
  - Start=1 with Op in {000..011}: latch operands and compute operand magnitudes for signed ops. Latch sign flags: product/quotient negative = signA XOR signB; remainder negative = signA. Set counter=0 and go to RUN. Busy=1 from the cycle after this edge.
  - Start=1 with MTHI (100): HI<=busA at that edge. MTLO (101): LO<=busA. Stay in IDLE; Busy and Done stay 0.
  - Start=1 with 110/111, or Start=0: no effect.
- RUN, one iteration per posedge, counter increments, 32 iterations:
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract, producing quotient and remainder.
  - After iteration 32 (counter==ITER-1 at the edge) go to FIX.
- FIX, one edge:
  - Apply sign correction: negate the 64-bit product, quotient and/or remainder per latched flags.
  - Write HI/LO, go to IDLE. Busy falls and Done=1 for exactly the following cycle.
- Latency: Start edge = edge 0; result visible in HI/LO after edge 33; Busy high for 33 cycles; Done high in cycle 34.
- HI/LO hold their previous values throughout RUN; they are not updated until FIX.
- Start while Busy=1 (any Op, including MTHI/MTLO) is ignored; the pipeline must stall on Busy.
- Divide by zero (DIV or DIVU): still 33 cycles; result forced to HI=busA (original, unsigned bit pattern), LO=32'hFFFFFFFF.
- Signed overflow 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0 (falls out of the magnitude algorithm; no exception).
- Signed semantics: MULT gives the 64-bit two's-complement product. DIV truncates toward zero; the remainder takes the dividend's sign.
- Unsigned ops: no sign latching, no negation in FIX.
- Done and Busy are never high in the same cycle.

Decomposition:
- Shared package holds:
  - Op encodings: OP_MULTU, OP_MULT, OP_DIVU, OP_DIV, OP_MTHI, OP_MTLO.
  - State encoding: S_IDLE, S_RUN, S_FIX.
  - WIDTH default.
- One natural sub-module: muldiv_step, a combinational single-iteration datapath.
  - Inputs: mode, 64-bit accumulator, operand.
  - Outputs: next accumulator.
  - mul_div_unit owns the FSM, counter, sign flags and HI/LO.

Test Plan:
- Reset mid-operation: MULTU 3x5, assert Reset at cycle 10 -> Busy=0, HI=0, LO=0 immediately (asynchronously); no Done pulse follows.
- MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 cycles HI=0xFFFFFFFE, LO=0x00000001, Done one cycle. MULT with same operands -> HI=0, LO=1.
- DIV -7 / 2 -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU 100 / 7 -> LO=14, HI=2.
- DIVU 0x1234 / 0 -> HI=0x1234, LO=0xFFFFFFFF after 33 cycles. DIV 0x80000000 / -1 -> LO=0x80000000, HI=0.
- Ignored requests: MTHI 0xDEADBEEF while idle -> HI=0xDEADBEEF next edge, Busy stays 0. Then start MULTU and issue MTLO 0x1 during Busy -> ignored; LO equals the product's low half at completion.
- Back-to-back: Start held high with MULT 2x3 -> second op accepted only on the edge where state is IDLE (cycle after FIX). Busy gap of exactly one cycle, coinciding with Done=1.
